seq_det_param: RTL

SEQ_DET_PARAM -- requirements
Module: seq_det_param

---
 rtl/seq_det_param.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - runtime-configurable serial pattern detector with match counter
//
// Purpose: watches a qualified serial bit stream for a programmable pattern of
// 2..MAX_LEN bits. Each match is reported as a one-cycle registered Moore flag
// and counted in a saturating counter. Overlapping or non-overlapping matching
// is selectable at configuration time.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset
//   in_valid     qualifies in; the bit is only consumed when high
//   in           serial data bit
//   cfg_load     one-cycle strobe that loads cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern  new pattern; cfg_pattern[cfg_len-1] is the first bit received
//   cfg_len      new pattern length, legal range 2..MAX_LEN
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   cnt_clr      synchronous clear of match_cnt (wins over a same-cycle hit)
//   out          registered match flag, high for the cycle after each hit
//   match_cnt    saturating count of hits
//   cfg_err      one-cycle pulse when a load is rejected for an illegal length

module seq_det_param #(
  parameter int                   MAX_LEN     = 8,
  parameter int                   CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'b0000_1011,
  parameter int                   DEF_LEN     = 4,
  parameter bit                   DEF_OVERLAP = 1'b1,
  localparam int                  LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [0:0] DETECT = 1'b0;
  localparam logic [0:0] MATCH  = 1'b1;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               cfg_ok;
  logic               hit;

  // Newest bit enters at the LSB so hist[len-1:0] lines up with pat[len-1:0].
  assign hist_shift = {hist_q[MAX_LEN-2:0], in};
  assign fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
  // Ones in the low len bits; history bits older than the pattern are ignored.
  assign len_mask   = ~({MAX_LEN{1'b1}} << len_q);
  assign cfg_ok     = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));

  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    hit     = 1'b0;

    if (cfg_load && cfg_ok) begin
      // An accepted load restarts detection; any same-cycle bit is dropped.
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = DETECT;
    end else begin
      // A rejected load only raises cfg_err; the bit path runs as usual.
      err_d = cfg_load;
      if (in_valid) begin
        hist_d = hist_shift;
        fill_d = fill_inc;
        if ((fill_inc >= len_q) && (((hist_shift ^ pat_q) & len_mask) == '0)) begin
          hit = 1'b1;
        end
        // Non-overlapping mode: the next match must be built from fresh bits.
        if (hit && !ovl_q) begin
          fill_d = '0;
        end
      end
      state_d = hit ? MATCH : DETECT;
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= DEF_PATTERN;
      len_q   <= LEN_W'(DEF_LEN);
      ovl_q   <= DEF_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= DETECT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign out       = (state_q == MATCH);
  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;

endmodule
